cnn_layer_1_window_sched: RTL and testbench

Frame-level sequencer for the layer-1 convolution engine. On `start` it walks every valid kernel-window origin of the input image in raster order. For each window it:
- requests the window's pixels from the feature fetcher;
- fires the engine's one-cycle `data_valid`;
- waits for the engine's `result_valid`;
- hands the output-buffer write address to the result writer.

It sits between the layer-1 top-level control and the conv/bias/ReLU engine, with one window in flight at a time.

---
 rtl/cnn_layer_1_window_sched.sv | 195 +++++++++++++++++++
 tb/tb_cnn_layer_1_window_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_1_window_sched.sv
// Layer-1 window sequencer: walks kernel-window origins in raster order, one window in flight.
// Optional WAIT watchdog enabled by defining CNN_L1_SCHED_TIMEOUT_EN.
module cnn_layer_1_window_sched #(
  parameter int unsigned IMG_W   = 28,
  parameter int unsigned IMG_H   = 28,
  parameter int unsigned KERNEL  = 5,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               win_req,
  input  logic               win_ack,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               eng_valid,
  input  logic               eng_result_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr
);

  localparam int unsigned OUT_W = (IMG_W - KERNEL) / STRIDE + 1;
  localparam int unsigned OUT_H = (IMG_H - KERNEL) / STRIDE + 1;

  localparam logic [COORD_W-1:0] XLast     = COORD_W'(OUT_W - 1);
  localparam logic [COORD_W-1:0] YLast     = COORD_W'(OUT_H - 1);
  localparam logic [COORD_W-1:0] CoordStep = COORD_W'(STRIDE);
  localparam logic [COORD_W-1:0] CoordOne  = COORD_W'(1);
  localparam logic [ADDR_W-1:0]  AddrOne   = ADDR_W'(1);

  // Elaboration-time sanity on the configuration.
  if (STRIDE < 1) begin : g_bad_stride
    $error("STRIDE must be at least 1");
  end
  if ((64'd1 << ADDR_W) < 64'(OUT_W * OUT_H)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for OUT_W*OUT_H");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StWrite,
    StNext,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_idx_q, x_idx_d;
  logic [COORD_W-1:0] y_idx_q, y_idx_d;
  logic [COORD_W-1:0] win_x_q, win_x_d;
  logic [COORD_W-1:0] win_y_q, win_y_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;

`ifdef CNN_L1_SCHED_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(TIMEOUT - 1);

  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      x_idx_q    <= '0;
      y_idx_q    <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      out_addr_q <= '0;
`ifdef CNN_L1_SCHED_TIMEOUT_EN
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_idx_q    <= x_idx_d;
      y_idx_q    <= y_idx_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      out_addr_q <= out_addr_d;
`ifdef CNN_L1_SCHED_TIMEOUT_EN
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    x_idx_d    = x_idx_q;
    y_idx_d    = y_idx_q;
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    out_addr_d = out_addr_q;
`ifdef CNN_L1_SCHED_TIMEOUT_EN
    err_d      = err_q;
    // Counter only advances while waiting; any other state parks it at zero.
    wait_cnt_d = '0;
`endif

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StFetch;
            x_idx_d    = '0;
            y_idx_d    = '0;
            win_x_d    = '0;
            win_y_d    = '0;
            out_addr_d = '0;
`ifdef CNN_L1_SCHED_TIMEOUT_EN
            err_d      = 1'b0;
`endif
          end
        end
        StFetch: begin
          if (win_ack) state_d = StIssue;
        end
        StIssue: begin
          state_d = StWait;
        end
        StWait: begin
          if (eng_result_valid) begin
            state_d = StWrite;
`ifdef CNN_L1_SCHED_TIMEOUT_EN
          end else if (wait_cnt_q == WaitLast) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
`endif
          end
        end
        StWrite: begin
          if (out_ready) state_d = StNext;
        end
        StNext: begin
          // Origins tracked by stride-step adders so no multiplier is needed.
          if (x_idx_q < XLast) begin
            x_idx_d    = x_idx_q + CoordOne;
            win_x_d    = win_x_q + CoordStep;
            out_addr_d = out_addr_q + AddrOne;
            state_d    = StFetch;
          end else if (y_idx_q < YLast) begin
            x_idx_d    = '0;
            win_x_d    = '0;
            y_idx_d    = y_idx_q + CoordOne;
            win_y_d    = win_y_q + CoordStep;
            out_addr_d = out_addr_q + AddrOne;
            state_d    = StFetch;
          end else begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign win_req   = (state_q == StFetch);
  assign eng_valid = (state_q == StIssue);
  assign out_valid = (state_q == StWrite);
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign out_addr  = out_addr_q;

`ifdef CNN_L1_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_1_window_sched.sv
// Scoreboard bench for cnn_layer_1_window_sched with randomized fetcher/engine/writer responders.
// Timeout checks adapt to whether CNN_L1_SCHED_TIMEOUT_EN is defined.
module tb_cnn_layer_1_window_sched;

  localparam int IMG_W   = 9;
  localparam int IMG_H   = 7;
  localparam int KERNEL  = 3;
  localparam int STRIDE  = 2;
  localparam int COORD_W = 5;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 8;
  localparam int OUT_W   = (IMG_W - KERNEL) / STRIDE + 1;
  localparam int OUT_H   = (IMG_H - KERNEL) / STRIDE + 1;
  localparam int NWIN    = OUT_W * OUT_H;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               err;
  logic               win_req;
  logic               win_ack;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;
  logic               eng_valid;
  logic               eng_result_valid;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;

  cnn_layer_1_window_sched #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .KERNEL  (KERNEL),
    .STRIDE  (STRIDE),
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .win_req          (win_req),
    .win_ack          (win_ack),
    .win_x            (win_x),
    .win_y            (win_y),
    .eng_valid        (eng_valid),
    .eng_result_valid (eng_result_valid),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int a;
  } win_t;

  win_t iss_q[$];
  win_t wr_q[$];

  int errors    = 0;
  int checks    = 0;
  int done_cnt  = 0;
  int exp_done  = 0;
  int issue_cnt = 0;
  int ack_p     = 100;
  int rdy_p     = 100;
  int res_p     = 100;
  int hold_idx  = -1;
  bit spur      = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: every window origin in raster order with its output index.
  task automatic push_frame();
    win_t w;
    iss_q.delete();
    wr_q.delete();
    for (int y = 0; y < OUT_H; y++) begin
      for (int x = 0; x < OUT_W; x++) begin
        w.x = x * STRIDE;
        w.y = y * STRIDE;
        w.a = y * OUT_W + x;
        iss_q.push_back(w);
        wr_q.push_back(w);
      end
    end
  endtask

  // Responders drive just after the rising edge so the next edge samples them.
  initial begin
    bit waiting;
    bit was_issue;
    waiting          = 1'b0;
    was_issue        = 1'b0;
    win_ack          = 1'b0;
    out_ready        = 1'b0;
    eng_result_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!busy) waiting = 1'b0;
      else if (waiting && eng_result_valid) waiting = 1'b0;
      if (was_issue) waiting = 1'b1;
      was_issue = eng_valid;
      win_ack   = win_req && ($urandom_range(1, 100) <= ack_p);
      out_ready = out_valid && ($urandom_range(1, 100) <= rdy_p);
      eng_result_valid = waiting && (hold_idx != issue_cnt - 1) &&
                         ($urandom_range(1, 100) <= res_p);
      if (spur && win_req && ($urandom_range(0, 1) == 1)) eng_result_valid = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a window or a write.
  initial begin
    win_t w;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (done) done_cnt++;
        if (win_req && iss_q.size() > 0) begin
          check("fetch_x", int'(win_x), iss_q[0].x);
          check("fetch_y", int'(win_y), iss_q[0].y);
        end
        if (eng_valid) begin
          issue_cnt++;
          if (iss_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_issue: got eng_valid at (%0d,%0d), expected none", win_x, win_y);
          end else begin
            w = iss_q.pop_front();
            check("issue_x", int'(win_x), w.x);
            check("issue_y", int'(win_y), w.y);
          end
        end
        if (out_valid) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_write: got out_valid at addr %0d, expected none", out_addr);
          end else begin
            check("write_x", int'(win_x), wr_q[0].x);
            check("write_y", int'(win_y), wr_q[0].y);
            check("write_addr", int'(out_addr), wr_q[0].a);
            if (out_ready) void'(wr_q.pop_front());
          end
        end
      end
    end
  end

  task automatic start_frame();
    push_frame();
    issue_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("win_req_rise", win_req, 1);
    check("start_x", int'(win_x), 0);
    check("start_y", int'(win_y), 0);
    check("start_addr", int'(out_addr), 0);
    check("start_err", err, 0);
  endtask

  task automatic wait_done(input bit stray, output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = stray && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", cyc);
    end
  endtask

  task automatic end_frame();
    check("err_end", err, 0);
    exp_done++;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("iss_left", iss_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
    check("done_count", done_cnt, exp_done);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_win_req"}, win_req, 0);
    check({tag, "_eng_valid"}, eng_valid, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_win_x"}, int'(win_x), 0);
    check({tag, "_win_y"}, int'(win_y), 0);
    check({tag, "_out_addr"}, int'(out_addr), 0);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Immediate handshakes: five cycles per window.
    start_frame();
    wait_done(1'b0, cyc);
    check("frame_cycles", cyc, NWIN * 5);
    end_frame();

    // Random handshake delays, spurious results in FETCH, stray starts while busy.
    spur = 1'b1;
    for (int f = 0; f < 3; f++) begin
      ack_p = $urandom_range(25, 90);
      rdy_p = $urandom_range(25, 90);
      res_p = $urandom_range(20, 90);
      start_frame();
      wait_done(1'b1, cyc);
      end_frame();
    end
    spur = 1'b0;

    // Abort while window 2 waits for its result.
    hold_idx = 1;
    start_frame();
    cyc = 0;
    while (issue_cnt < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_win2", issue_cnt, 2);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_win_req", win_req, 0);
    check("abort_eng_valid", eng_valid, 0);
    check("abort_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, exp_done);
    check("abort_issue_count", issue_cnt, 2);
    hold_idx = -1;
    start_frame();
    wait_done(1'b0, cyc);
    end_frame();

    // Asynchronous reset mid-frame.
    start_frame();
    repeat (17) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    iss_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clk);
    check("reset_no_done", done_cnt, exp_done);

    // Engine never answers window 0.
    ack_p    = 100;
    rdy_p    = 100;
    res_p    = 100;
    hold_idx = 0;
    start_frame();
`ifdef CNN_L1_SCHED_TIMEOUT_EN
    wait_done(1'b0, cyc);
    check("timeout_cycles", cyc, 2 + TIMEOUT);
    check("timeout_err", err, 1);
    exp_done++;
    @(negedge clk);
    check("timeout_idle", busy, 0);
    check("timeout_err_hold", err, 1);
    check("timeout_done_count", done_cnt, exp_done);
    hold_idx = -1;
    start_frame();
    wait_done(1'b0, cyc);
    end_frame();
`else
    repeat (40) @(negedge clk);
    check("stall_busy", busy, 1);
    check("stall_err", err, 0);
    check("stall_no_done", done_cnt, exp_done);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("stall_abort_busy", busy, 0);
    hold_idx = -1;
`endif

    repeat (2) @(negedge clk);
    check("final_done_count", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 time units, expected summary");
    $fatal(1, "watchdog expired");
  end

endmodule
